// File: rtl/sam_mem_arbiter.sv
// -----------------------------------------------------------------------------
// sam_mem_arbiter
//
// Single-port RAM arbiter between the PicoRV32 native memory interface and the
// SAM accelerator's memory master. CPU requests are served as a fixed
// 2-cycle-latency transaction (issue, response, done). SAM gets exclusive
// streaming ownership of the RAM for as long as sam_en stays high. An accepted
// CPU transaction always completes before SAM is granted.
//
// Optional feature (macro SAM_ARB_OOR_ERR_EN): sticky out-of-range error flag
// plus a latch of the first offending byte address. Without the macro both
// outputs are tied to zero.
//
// Ports
//   clk, resetn            : clock, asynchronous active-low reset
//   cpu_valid/instr/addr/wdata/wstrb : PicoRV32 request (wstrb==0 -> read)
//   cpu_ready, cpu_rdata   : registered one-cycle completion pulse + read data
//   sam_en                 : SAM ownership request, held for the whole job
//   sam_grant              : SAM may access the RAM while high
//   sam_addr/wdata/wstrb   : SAM access fields, one access per granted cycle
//   sam_rdata, sam_rvalid  : read data (RAM output) and its valid strobe
//   mem_ce/we/addr/wdata   : RAM port (word addressed, we qualified by ce)
//   mem_rdata              : RAM read data, one cycle after mem_ce
//   oor_err, oor_addr      : sticky out-of-range flag and first bad address
// -----------------------------------------------------------------------------
module sam_mem_arbiter #(
  parameter int MEM_WORDS = 256,
  parameter int AW        = $clog2(MEM_WORDS)
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          cpu_valid,
  input  logic          cpu_instr,
  input  logic [31:0]   cpu_addr,
  input  logic [31:0]   cpu_wdata,
  input  logic [3:0]    cpu_wstrb,
  output logic          cpu_ready,
  output logic [31:0]   cpu_rdata,
  input  logic          sam_en,
  output logic          sam_grant,
  input  logic [31:0]   sam_addr,
  input  logic [31:0]   sam_wdata,
  input  logic [3:0]    sam_wstrb,
  output logic [31:0]   sam_rdata,
  output logic          sam_rvalid,
  output logic          mem_ce,
  output logic [3:0]    mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata,
  output logic          oor_err,
  output logic [31:0]   oor_addr
);

  localparam logic [31:0] ADDR_LIMIT = 32'(MEM_WORDS * 4);

  typedef enum logic [1:0] {IDLE, CPU_RESP, CPU_DONE, SAM_OWN} state_t;

  state_t        state_reg, state_next;
  logic          cpu_ready_reg;
  logic [31:0]   cpu_rdata_reg;
  logic          cpu_oor_reg;     // issued CPU access was out of range
  logic          sam_grant_reg;
  logic          sam_rvalid_reg;

  logic          cpu_in_range, sam_in_range;
  logic          cpu_issue, sam_access;
  logic          ce_next;
  logic [3:0]    we_next;
  logic [AW-1:0] addr_next;
  logic [31:0]   wdata_next;

  // cpu_instr is informational only on this port.
  logic unused_inputs;
  assign unused_inputs = &{1'b0, cpu_instr};

  assign cpu_in_range = (cpu_addr < ADDR_LIMIT);
  assign sam_in_range = (sam_addr < ADDR_LIMIT);

  always_comb begin
    state_next = state_reg;
    cpu_issue  = 1'b0;
    sam_access = 1'b0;
    ce_next    = 1'b0;
    we_next    = '0;
    addr_next  = '0;
    wdata_next = '0;
    case (state_reg)
      IDLE: begin
        // SAM wins a tie with a simultaneous CPU request.
        if (sam_en) begin
          state_next = SAM_OWN;
        end else if (cpu_valid) begin
          cpu_issue  = 1'b1;
          ce_next    = cpu_in_range;
          we_next    = cpu_in_range ? cpu_wstrb : 4'b0000;
          addr_next  = cpu_addr[AW+1:2];
          wdata_next = cpu_wdata;
          state_next = CPU_RESP;
        end
      end
      CPU_RESP: state_next = CPU_DONE;
      CPU_DONE: state_next = IDLE;
      SAM_OWN: begin
        if (sam_en) begin
          sam_access = 1'b1;
          ce_next    = sam_in_range;
          we_next    = sam_in_range ? sam_wstrb : 4'b0000;
          addr_next  = sam_addr[AW+1:2];
          wdata_next = sam_wdata;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Gating with resetn keeps the RAM quiet the instant reset asserts,
  // suppressing any write in flight for the current cycle.
  assign mem_ce    = ce_next & resetn;
  assign mem_we    = we_next & {4{resetn}};
  assign mem_addr  = addr_next;
  assign mem_wdata = wdata_next;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg      <= IDLE;
      cpu_ready_reg  <= 1'b0;
      cpu_rdata_reg  <= '0;
      cpu_oor_reg    <= 1'b0;
      sam_grant_reg  <= 1'b0;
      sam_rvalid_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cpu_ready_reg <= (state_reg == CPU_RESP);
      if (cpu_issue) begin
        cpu_oor_reg <= ~cpu_in_range;
      end
      if (state_reg == CPU_RESP) begin
        cpu_rdata_reg <= cpu_oor_reg ? 32'h0 : mem_rdata;
      end
      sam_grant_reg  <= (state_next == SAM_OWN);
      sam_rvalid_reg <= sam_access & sam_in_range;
    end
  end

  assign cpu_ready  = cpu_ready_reg;
  assign cpu_rdata  = cpu_rdata_reg;
  assign sam_grant  = sam_grant_reg;
  assign sam_rvalid = sam_rvalid_reg;
  assign sam_rdata  = mem_rdata;

`ifdef SAM_ARB_OOR_ERR_EN
  logic        oor_err_reg;
  logic [31:0] oor_addr_reg;
  logic        cpu_oor_access, sam_oor_access;

  assign cpu_oor_access = cpu_issue & ~cpu_in_range;
  assign sam_oor_access = sam_access & ~sam_in_range;

  // Only the first offending access is recorded; both hold until reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      oor_err_reg  <= 1'b0;
      oor_addr_reg <= '0;
    end else if (!oor_err_reg && (cpu_oor_access || sam_oor_access)) begin
      oor_err_reg  <= 1'b1;
      oor_addr_reg <= cpu_oor_access ? cpu_addr : sam_addr;
    end
  end

  assign oor_err  = oor_err_reg;
  assign oor_addr = oor_addr_reg;
`else
  assign oor_err  = 1'b0;
  assign oor_addr = 32'h0;
`endif

endmodule

// File: tb/tb_sam_mem_arbiter.sv
// -----------------------------------------------------------------------------
// Directed testbench for sam_mem_arbiter with a behavioural synchronous RAM.
// Inputs change after the falling edge; outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_sam_mem_arbiter;

  localparam int MEM_WORDS = 256;
  localparam int AW        = $clog2(MEM_WORDS);

  logic          clk = 1'b0;
  logic          resetn;
  logic          cpu_valid, cpu_instr;
  logic [31:0]   cpu_addr, cpu_wdata;
  logic [3:0]    cpu_wstrb;
  logic          cpu_ready;
  logic [31:0]   cpu_rdata;
  logic          sam_en;
  logic          sam_grant;
  logic [31:0]   sam_addr, sam_wdata;
  logic [3:0]    sam_wstrb;
  logic [31:0]   sam_rdata;
  logic          sam_rvalid;
  logic          mem_ce;
  logic [3:0]    mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;
  logic          oor_err;
  logic [31:0]   oor_addr;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sam_mem_arbiter #(.MEM_WORDS(MEM_WORDS)) dut (
    .clk(clk), .resetn(resetn),
    .cpu_valid(cpu_valid), .cpu_instr(cpu_instr), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_wstrb(cpu_wstrb),
    .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata),
    .sam_en(sam_en), .sam_grant(sam_grant), .sam_addr(sam_addr),
    .sam_wdata(sam_wdata), .sam_wstrb(sam_wstrb),
    .sam_rdata(sam_rdata), .sam_rvalid(sam_rvalid),
    .mem_ce(mem_ce), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .oor_err(oor_err), .oor_addr(oor_addr)
  );

  // Behavioural RAM: read-before-write, byte enables, preloaded on first edge.
  logic [31:0] ram [MEM_WORDS];
  bit          ram_init_done;

  function automatic logic [31:0] init_word(input int i);
    case (i)
      3:       return 32'h0000_094B;
      10, 11:  return 32'd3;
      12:      return 32'd4;
      13:      return 32'd5;
      14:      return 32'd3;
      15:      return 32'd4;
      16:      return 32'd5;
      18:      return 32'h0;
      default: return 32'hDEAD_0000 | 32'(i);
    endcase
  endfunction

  always @(posedge clk) begin
    if (!ram_init_done) begin
      for (int i = 0; i < MEM_WORDS; i++) ram[i] <= init_word(i);
      ram_init_done <= 1'b1;
    end else if (mem_ce) begin
      mem_rdata <= ram[mem_addr];
      for (int b = 0; b < 4; b++)
        if (mem_we[b]) ram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
  end

  task automatic check_value(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", tag, actual, expected);
    end else begin
      $display("ok   %s value=0x%08h", tag, actual);
    end
  endtask

  // One CPU transaction; call after a falling edge with the arbiter in IDLE.
  task automatic cpu_xfer(input string tag, input logic [31:0] a,
                          input logic [31:0] wd, input logic [3:0] ws,
                          output logic [31:0] rd);
    cpu_valid = 1'b1; cpu_addr = a; cpu_wdata = wd; cpu_wstrb = ws;
    @(posedge clk);                      // E0: access issued
    @(negedge clk);
    check_value({tag, "_ready_e0"}, 32'(cpu_ready), 32'd0);
    @(posedge clk);                      // E1: response registered
    @(negedge clk);
    check_value({tag, "_ready_e1"}, 32'(cpu_ready), 32'd1);
    rd = cpu_rdata;
    @(posedge clk);                      // E2: CPU drops valid
    #1 cpu_valid = 1'b0; cpu_wstrb = 4'b0000;
    @(negedge clk);
    check_value({tag, "_ready_e2"}, 32'(cpu_ready), 32'd0);
  endtask

  localparam logic [31:0] STREAM_EXP [7] = '{32'd3, 32'd3, 32'd4, 32'd5,
                                             32'd3, 32'd4, 32'd5};
`ifdef SAM_ARB_OOR_ERR_EN
  localparam logic [31:0] OOR_ERR_EXP  = 32'd1;
  localparam logic [31:0] OOR_ADDR_EXP = 32'h0000_0400;
`else
  localparam logic [31:0] OOR_ERR_EXP  = 32'd0;
  localparam logic [31:0] OOR_ADDR_EXP = 32'h0;
`endif

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "simulation timeout");
  end

  initial begin
    logic [31:0] rd;
    resetn = 1'b0; cpu_valid = 1'b0; cpu_instr = 1'b0; cpu_addr = '0;
    cpu_wdata = '0; cpu_wstrb = '0; sam_en = 1'b0; sam_addr = '0;
    sam_wdata = '0; sam_wstrb = '0;
    repeat (3) @(negedge clk);
    check_value("rst_cpu_ready",  32'(cpu_ready),  32'd0);
    check_value("rst_cpu_rdata",  cpu_rdata,       32'd0);
    check_value("rst_sam_grant",  32'(sam_grant),  32'd0);
    check_value("rst_sam_rvalid", 32'(sam_rvalid), 32'd0);
    check_value("rst_mem_ce",     32'(mem_ce),     32'd0);
    check_value("rst_oor_err",    32'(oor_err),    32'd0);
    check_value("rst_oor_addr",   oor_addr,        32'd0);
    resetn = 1'b1;
    @(negedge clk);

    // CPU read of RAM[3]
    cpu_xfer("cpu_rd3", 32'h0C, 32'h0, 4'b0000, rd);
    check_value("cpu_rd3_data", rd, 32'h0000_094B);

    // Partial write to 0x28 then read back
    cpu_xfer("cpu_pwr", 32'h28, 32'hAABB_CCDD, 4'b0011, rd);
    cpu_xfer("cpu_prd", 32'h28, 32'h0, 4'b0000, rd);
    check_value("cpu_prd_data", rd, 32'h0000_CCDD);
    cpu_xfer("cpu_rst10", 32'h28, 32'h3, 4'b1111, rd);

    // Out-of-range CPU write: aliases onto RAM[0] if not dropped
    cpu_xfer("cpu_oor", 32'h400, 32'h1234_5678, 4'b1111, rd);
    check_value("cpu_oor_rdata", rd, 32'h0);
    check_value("oor_err",  32'(oor_err), OOR_ERR_EXP);
    check_value("oor_addr", oor_addr,     OOR_ADDR_EXP);
    cpu_xfer("cpu_rd0", 32'h0, 32'h0, 4'b0000, rd);
    check_value("cpu_rd0_unchanged", rd, 32'hDEAD_0000);

    // Contention: CPU issued at E0, sam_en sampled at E1
    cpu_valid = 1'b1; cpu_addr = 32'h0C; cpu_wstrb = 4'b0000;
    @(posedge clk);                      // E0
    #1 sam_en = 1'b1;
    @(negedge clk);
    check_value("cont_ready_e0", 32'(cpu_ready), 32'd0);
    @(posedge clk);                      // E1
    @(negedge clk);
    check_value("cont_ready_e1", 32'(cpu_ready), 32'd1);
    check_value("cont_rdata",    cpu_rdata,      32'h0000_094B);
    check_value("cont_grant_e1", 32'(sam_grant), 32'd0);
    @(posedge clk);                      // E2
    #1 cpu_valid = 1'b0;
    @(negedge clk);
    check_value("cont_ready_e2", 32'(cpu_ready), 32'd0);
    check_value("cont_grant_e2", 32'(sam_grant), 32'd0);
    @(posedge clk);                      // E3
    @(negedge clk);
    check_value("cont_grant_e3", 32'(sam_grant), 32'd1);

    // SAM streaming reads 0x28..0x40
    for (int k = 0; k < 7; k++) begin
      sam_addr = 32'h28 + 32'(4 * k);
      @(posedge clk);
      @(negedge clk);
      check_value($sformatf("sam_rvalid_%0d", k), 32'(sam_rvalid), 32'd1);
      check_value($sformatf("sam_rdata_%0d", k),  sam_rdata, STREAM_EXP[k]);
    end
    sam_addr = 32'h48; sam_wdata = 32'h1F; sam_wstrb = 4'b1111;
    @(posedge clk);
    @(negedge clk);
    check_value("sam_wr_rvalid", 32'(sam_rvalid), 32'd1);
    sam_addr = 32'h800; sam_wstrb = 4'b0000;
    @(posedge clk);
    @(negedge clk);
    check_value("sam_oor_rvalid", 32'(sam_rvalid), 32'd0);
    check_value("sam_oor_sticky", oor_addr,        OOR_ADDR_EXP);
    sam_en = 1'b0;
    #1 check_value("rel_mem_ce", 32'(mem_ce), 32'd0);
    check_value("rel_grant_before", 32'(sam_grant), 32'd1);
    @(posedge clk);
    @(negedge clk);
    check_value("rel_grant", 32'(sam_grant), 32'd0);
    cpu_xfer("cpu_rd18", 32'h48, 32'h0, 4'b0000, rd);
    check_value("cpu_rd18_data", rd, 32'h0000_001F);

    // Reset during a granted SAM write
    sam_en = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_value("rst2_grant", 32'(sam_grant), 32'd1);
    sam_addr = 32'h0C; sam_wstrb = 4'b0000;
    @(posedge clk);
    @(negedge clk);
    check_value("rst2_rvalid_pre", 32'(sam_rvalid), 32'd1);
    sam_addr = 32'h50; sam_wdata = 32'hCAFE_F00D; sam_wstrb = 4'b1111;
    #1 resetn = 1'b0;
    #1;
    check_value("rst2_grant_async",  32'(sam_grant),  32'd0);
    check_value("rst2_rvalid_async", 32'(sam_rvalid), 32'd0);
    check_value("rst2_mem_ce_async", 32'(mem_ce),     32'd0);
    check_value("rst2_mem_we_async", 32'(mem_we),     32'd0);
    @(posedge clk);
    @(negedge clk);
    sam_en = 1'b0; sam_wstrb = 4'b0000;
    resetn = 1'b1;
    @(negedge clk);
    check_value("rst2_oor_cleared", 32'(oor_err), 32'd0);
    cpu_xfer("cpu_rd20", 32'h50, 32'h0, 4'b0000, rd);
    check_value("cpu_rd20_unwritten", rd, 32'hDEAD_0014);
    cpu_xfer("cpu_rd3b", 32'h0C, 32'h0, 4'b0000, rd);
    check_value("cpu_rd3b_data", rd, 32'h0000_094B);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
